// File: rtl/adc_frame_sequencer_pkg.sv
// Shared types and helpers for the ADC frame sequencer: FSM encoding,
// default sizes and set-bit search functions over a channel mask.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CONV  = 2'd2,
        WRITE = 2'd3
    } seq_state_t;

    localparam int NCH_DEF            = 8;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int TCNT_W_DEF         = $clog2(TIMEOUT_CYCLES_DEF);

    // Helpers operate on a 32-bit mask; callers zero-extend narrower masks.
    localparam int MASK_W     = 32;
    localparam int MASK_IDX_W = 5;

    // Lowest set bit at or above position 'from'; returns 0 when none is set.
    function automatic logic [MASK_IDX_W-1:0] next_set_bit(
        input logic [MASK_W-1:0]     mask,
        input logic [MASK_IDX_W-1:0] from
    );
        logic [MASK_IDX_W-1:0] pos;
        logic                  found;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < MASK_W; i++) begin
            if (!found && mask[i] && (i >= int'(from))) begin
                pos   = MASK_IDX_W'(i);
                found = 1'b1;
            end
        end
        return pos;
    endfunction

    function automatic logic [MASK_IDX_W-1:0] lowest_set_bit(input logic [MASK_W-1:0] mask);
        return next_set_bit(mask, '0);
    endfunction

    function automatic logic has_bit_above(
        input logic [MASK_W-1:0]     mask,
        input logic [MASK_IDX_W-1:0] idx
    );
        logic any;
        any = 1'b0;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i] && (i > int'(idx))) any = 1'b1;
        end
        return any;
    endfunction

endpackage

// File: rtl/adc_frame_sequencer_if.sv
// ADC converter port and frame-FIFO write port of the sequencer.
interface adc_frame_sequencer_if #(
    parameter int NCH = 8
);
    // No backpressure on either side: ADC_START and DONE are one-cycle strobes,
    // ADC_CHSEL is held from START through CONV, ADC_RESULT is valid only
    // with ADC_DONE, and RESULT/ATMCHSEL/LASTWORD are valid only with DONE.
    logic                   ADC_START;
    logic [$clog2(NCH)-1:0] ADC_CHSEL;
    logic                   ADC_DONE;
    logic [15:0]            ADC_RESULT;
    logic                   DONE;
    logic [15:0]            RESULT;
    logic [NCH-1:0]         ATMCHSEL;
    logic                   LASTWORD;

    modport master (
        output ADC_START, ADC_CHSEL, DONE, RESULT, ATMCHSEL, LASTWORD,
        input  ADC_DONE, ADC_RESULT
    );

    modport slave (
        input  ADC_START, ADC_CHSEL, DONE, RESULT, ATMCHSEL, LASTWORD,
        output ADC_DONE, ADC_RESULT
    );

endinterface

// File: rtl/adc_frame_sequencer_tick_gen.sv
// Frame tick divider: one tick every FRAMEDIV+1 cycles while sampling is enabled.
module frame_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 SAMPLE_CLK,
    input  logic                 RST_sync,
    input  logic                 ENSAMP_sync,
    input  logic [DIV_WIDTH-1:0] FRAMEDIV,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_cnt;

    // >= lets a FRAMEDIV lowered below the running count wrap at once.
    always_ff @(posedge SAMPLE_CLK) begin
        if (RST_sync || !ENSAMP_sync) begin
            div_cnt <= '0;
        end else if (div_cnt >= FRAMEDIV) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    assign tick = ENSAMP_sync && (div_cnt >= FRAMEDIV);

endmodule

// File: rtl/adc_frame_sequencer.sv
// Per-frame ADC channel sequencer: converts every enabled channel on each
// frame tick and writes the results to the frame FIFO, last word flagged.
module adc_frame_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NCH            = NCH_DEF,
    parameter int DIV_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   SAMPLE_CLK,
    input  logic                   RST_sync,
    input  logic                   ENSAMP_sync,
    input  logic [NCH-1:0]         CHEN,
    input  logic [DIV_WIDTH-1:0]   FRAMEDIV,
    adc_frame_sequencer_if.master  bus,
    output logic                   SEQ_BUSY,
    output logic                   FRAME_OVERRUN,
    output logic                   ADC_TIMEOUT,
    output seq_state_t             seq_state
);

    localparam int IW = $clog2(NCH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic           tick;
    seq_state_t     state_q, state_d;
    logic [NCH-1:0] chen_q;
    logic [IW-1:0]  idx_q;
    logic [TW-1:0]  tcnt_q;
    logic [15:0]    cap_q;

    logic [NCH-1:0] idx_onehot;
    logic [NCH-1:0] chen_rest;
    logic           frame_go;
    logic           conv_finish;
    logic           conv_expire;

    logic           start_d, done_d, last_d, busy_d;
    logic [NCH-1:0] atm_d;
    logic           start_q, done_q, last_q, busy_q;
    logic [NCH-1:0] atm_q;
    logic           overrun_q, timeout_q;

    frame_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .SAMPLE_CLK  (SAMPLE_CLK),
        .RST_sync    (RST_sync),
        .ENSAMP_sync (ENSAMP_sync),
        .FRAMEDIV    (FRAMEDIV),
        .tick        (tick)
    );

    assign idx_onehot  = NCH'(1) << idx_q;
    assign chen_rest   = chen_q & ~idx_onehot;
    assign frame_go    = tick && (CHEN != '0);
    assign conv_finish = (state_q == CONV) && (bus.ADC_DONE || (tcnt_q == TCNT_LAST));
    // A strobe on the expiry cycle still counts as a completed conversion.
    assign conv_expire = (state_q == CONV) && !bus.ADC_DONE && (tcnt_q == TCNT_LAST);

    always_ff @(posedge SAMPLE_CLK) begin : state_reg
        if (RST_sync) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (!ENSAMP_sync) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (frame_go) state_d = START;
                START:   state_d = CONV;
                CONV:    if (conv_finish) state_d = WRITE;
                WRITE:   state_d = (chen_rest != '0) ? START : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge SAMPLE_CLK) begin : datapath
        if (RST_sync) begin
            chen_q <= '0;
            idx_q  <= '0;
            tcnt_q <= '0;
            cap_q  <= '0;
        end else if (!ENSAMP_sync) begin
            chen_q <= '0;
            idx_q  <= '0;
            tcnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_go) begin
                        chen_q <= CHEN;
                        idx_q  <= IW'(lowest_set_bit(MASK_W'(CHEN)));
                    end
                end
                START: begin
                    tcnt_q <= '0;
                end
                CONV: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (bus.ADC_DONE) begin
                        cap_q <= bus.ADC_RESULT;
                    end else if (tcnt_q == TCNT_LAST) begin
                        cap_q <= '0;
                    end
                end
                WRITE: begin
                    chen_q <= chen_rest;
                    if (chen_rest != '0) begin
                        idx_q <= IW'(next_set_bit(MASK_W'(chen_q),
                                                  MASK_IDX_W'(idx_q) + MASK_IDX_W'(1)));
                    end
                end
                default: ;
            endcase
        end
    end

    // Output values are decoded from the next state so every port is a flop.
    always_comb begin : outputs_next
        start_d = (state_d == START);
        done_d  = (state_d == WRITE);
        last_d  = done_d && !has_bit_above(MASK_W'(chen_q), MASK_IDX_W'(idx_q));
        atm_d   = done_d ? idx_onehot : '0;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge SAMPLE_CLK) begin : output_reg
        if (RST_sync) begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            atm_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            done_q  <= done_d;
            last_q  <= last_d;
            atm_q   <= atm_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge SAMPLE_CLK) begin : event_toggles
        if (RST_sync) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (tick && (state_q != IDLE)) overrun_q <= ~overrun_q;
            if (ENSAMP_sync && conv_expire) timeout_q <= ~timeout_q;
        end
    end

    assign bus.ADC_START  = start_q;
    assign bus.ADC_CHSEL  = idx_q;
    assign bus.DONE       = done_q;
    assign bus.RESULT     = cap_q;
    assign bus.ATMCHSEL   = atm_q;
    assign bus.LASTWORD   = last_q;
    assign SEQ_BUSY       = busy_q;
    assign FRAME_OVERRUN  = overrun_q;
    assign ADC_TIMEOUT    = timeout_q;
    assign seq_state      = state_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Bench for adc_frame_sequencer: an ADC responder plus a frame-level model
// predicts every FIFO word, conversion time, overrun and timeout event.
module tb_adc_frame_sequencer;
    import adc_seq_pkg::*;

    localparam int NCH            = 8;
    localparam int DIV_WIDTH      = 16;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int W              = 16 + NCH + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ensamp;
    logic [NCH-1:0]       chen;
    logic [DIV_WIDTH-1:0] framediv;
    logic                 seq_busy;
    logic                 frame_overrun;
    logic                 adc_timeout;
    seq_state_t           seq_state;

    adc_frame_sequencer_if #(.NCH(NCH)) bus ();

    adc_frame_sequencer #(
        .NCH            (NCH),
        .DIV_WIDTH      (DIV_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .SAMPLE_CLK    (clk),
        .RST_sync      (rst),
        .ENSAMP_sync   (ensamp),
        .CHEN          (chen),
        .FRAMEDIV      (framediv),
        .bus           (bus),
        .SEQ_BUSY      (seq_busy),
        .FRAME_OVERRUN (frame_overrun),
        .ADC_TIMEOUT   (adc_timeout),
        .seq_state     (seq_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // model and scoreboard state
    logic [W-1:0]   exp_q[$];
    int             plan_q[$];
    int             conv_q[$];
    int             sc_q[$];
    logic [15:0]    res_q[$];
    int             fs_q[$];
    logic [NCH-1:0] chen_snap = '0;
    int             adc_cnt   = 0;
    bit             adc_mute  = 1'b0;
    int             adc_lat   = 5;
    int             n_done    = 0;
    int             n_starts  = 0;
    int             ovr_flips = 0;
    int             to_flips  = 0;
    bit             busy_seen = 1'b0;
    logic [NCH-1:0] last_atm  = '0;

    function automatic logic [W-1:0] model_word(input int ch, input logic [15:0] res,
                                                input logic [NCH-1:0] mask);
        int hi;
        hi = -1;
        for (int i = 0; i < NCH; i++) if (mask[i]) hi = i;
        return {res, NCH'(1 << ch), (ch == hi)};
    endfunction

    // ADC responder: DONE lands adc_lat+1 cycles after the START cycle
    initial begin
        bus.ADC_DONE   = 1'b0;
        bus.ADC_RESULT = '0;
        forever begin
            @(negedge clk);
            bus.ADC_DONE = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    logic [15:0] v;
                    v = 16'($urandom);
                    bus.ADC_DONE   = 1'b1;
                    bus.ADC_RESULT = v;
                    res_q.push_back(v);
                end
            end
            if (bus.ADC_START) begin
                if (adc_mute) res_q.push_back(16'h0000);
                else adc_cnt = adc_lat + 1;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic prev_start, prev_done, prev_ovr, prev_to;
        prev_start = 1'b0; prev_done = 1'b0; prev_ovr = 1'b0; prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ADC_START) begin
                if (prev_start) check("start_width", 1, 0);
                if (plan_q.size() == 0) begin
                    chen_snap = chen;
                    for (int i = 0; i < NCH; i++) if (chen[i]) plan_q.push_back(i);
                    fs_q.push_back(cyc);
                end
                if (plan_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    int ch;
                    ch = plan_q.pop_front();
                    check("adc_chsel", 32'(bus.ADC_CHSEL), ch);
                    conv_q.push_back(ch);
                    sc_q.push_back(cyc);
                end
                n_starts++;
            end
            if (bus.DONE) begin
                if (prev_done) check("done_width", 1, 0);
                if (conv_q.size() == 0 || res_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    int ch, s;
                    ch = conv_q.pop_front();
                    s  = sc_q.pop_front();
                    exp_q.push_back(model_word(ch, res_q.pop_front(), chen_snap));
                    check("word", 32'({bus.RESULT, bus.ATMCHSEL, bus.LASTWORD}), 32'(exp_q.pop_front()));
                    check("conv_cycles", cyc - s, adc_mute ? TIMEOUT_CYCLES + 1 : adc_lat + 2);
                end
                last_atm = bus.ATMCHSEL;
                n_done++;
            end
            if (seq_busy) busy_seen = 1'b1;
            if (frame_overrun !== prev_ovr) ovr_flips++;
            if (adc_timeout !== prev_to) to_flips++;
            prev_start = bus.ADC_START;
            prev_done  = bus.DONE;
            prev_ovr   = frame_overrun;
            prev_to    = adc_timeout;
        end
    end

    // driver tasks
    task automatic clear_model();
        plan_q.delete(); conv_q.delete(); sc_q.delete(); res_q.delete(); fs_q.delete();
        adc_cnt = 0;
    endtask

    task automatic start_phase(input logic [NCH-1:0] c, input int div, input int lat, input bit mute);
        @(negedge clk); #1;
        chen = c; framediv = DIV_WIDTH'(div); adc_lat = lat; adc_mute = mute; ensamp = 1'b1;
    endtask

    task automatic stop_phase();
        @(negedge clk); #1;
        ensamp = 1'b0;
        repeat (2) @(negedge clk);
        #1 clear_model();
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int target, k;
        target = n_done + n;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, n_done >= target, 1);
    endtask

    initial begin
        int ov0, to0, d0, s0, nw;
        logic tov, oov;
        logic [NCH-1:0] c;
        bit found;

        rst = 1'b1; ensamp = 1'b0; chen = '0; framediv = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_start", bus.ADC_START, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_last", bus.LASTWORD, 0);
        check("rst_atm", 32'(bus.ATMCHSEL), 0);
        check("rst_result", 32'(bus.RESULT), 0);
        check("rst_busy", seq_busy, 0);
        check("rst_toggles", {frame_overrun, adc_timeout}, 0);
        check("rst_state", 32'(seq_state), 32'(IDLE));
        rst = 1'b0;

        // nominal frames, with a mid-frame CHEN change that must wait a frame
        ov0 = ovr_flips; to0 = to_flips;
        start_phase(8'hA5, 99, 5, 1'b0);
        wait_words(4, 300, "frame_a5_first");
        wait_words(2, 300, "frame_a5_half");
        c = NCH'($urandom_range(1, 255));
        chen = c;
        wait_words(2, 300, "frame_a5_rest");
        wait_words(2 * $countones(c), 400, "frame_new_chen");
        check("frame_count", fs_q.size(), 4);
        for (int i = 1; i < fs_q.size(); i++) check("frame_period", fs_q[i] - fs_q[i-1], 100);
        check("nominal_overrun", ovr_flips - ov0, 0);
        check("nominal_timeout", to_flips - to0, 0);
        stop_phase();

        // random masks and latencies
        for (int it = 0; it < 3; it++) begin
            c = NCH'($urandom_range(1, 255));
            ov0 = ovr_flips;
            start_phase(c, 99, $urandom_range(0, 8), 1'b0);
            wait_words(2 * $countones(c), 400, "random_frames");
            check("random_overrun", ovr_flips - ov0, 0);
            stop_phase();
        end

        // empty mask: ticks run but nothing happens
        ov0 = ovr_flips; d0 = n_done; s0 = n_starts;
        start_phase('0, 9, 5, 1'b0);
        busy_seen = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check("empty_starts", n_starts - s0, 0);
        check("empty_done", n_done - d0, 0);
        check("empty_busy", busy_seen, 0);
        check("empty_overrun", ovr_flips - ov0, 0);
        stop_phase();

        // channel 3 never answers
        to0 = to_flips;
        start_phase(8'h08, 199, 5, 1'b1);
        wait_words(1, 300, "timeout_word");
        check("timeout_flips", to_flips - to0, 1);
        check("timeout_level", adc_timeout, 1);
        stop_phase();

        // DONE on the expiry cycle wins over the timeout
        to0 = to_flips;
        start_phase(8'h08, 199, TIMEOUT_CYCLES - 1, 1'b0);
        wait_words(1, 300, "edge_word");
        check("edge_timeout_flips", to_flips - to0, 0);
        stop_phase();

        // overruns: 8 channels at 8 cycles each against a 10-cycle tick
        ov0 = ovr_flips;
        start_phase(8'hFF, 9, 5, 1'b0);
        wait_words(8, 200, "overrun_words");
        check("overrun_flips", ovr_flips - ov0, 6);
        stop_phase();

        // sampling dropped while converting channel 2
        start_phase(8'h0E, 99, 5, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk); #1;
            if (bus.ADC_START && bus.ADC_CHSEL == 3'd2) found = 1'b1;
        end
        check("drop_found_ch2", found, 1);
        repeat (2) begin @(negedge clk); #1; end
        tov = adc_timeout; oov = frame_overrun;
        ensamp = 1'b0;
        @(negedge clk); #1;
        check("drop_busy", seq_busy, 0);
        check("drop_state", 32'(seq_state), 32'(IDLE));
        clear_model();
        d0 = n_done;
        repeat (20) @(negedge clk);
        #1;
        check("drop_no_done", n_done - d0, 0);
        check("drop_toggles_kept", {frame_overrun, adc_timeout}, {oov, tov});
        ensamp = 1'b1;
        wait_words(1, 300, "drop_reenable");
        check("drop_first_atm", 32'(last_atm), 32'h02);
        stop_phase();

        // reset mid-frame clears everything including the toggles
        start_phase(8'hFF, 99, 5, 1'b0);
        wait_words(2, 300, "reset_frame");
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_busy", seq_busy, 0);
        check("midrst_outputs", {bus.DONE, bus.ADC_START, bus.LASTWORD}, 0);
        check("midrst_toggles", {frame_overrun, adc_timeout}, 0);
        check("midrst_state", 32'(seq_state), 32'(IDLE));
        rst = 1'b0;
        clear_model();
        stop_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
